// File: rtl/result_drain.sv
// Result readout stage: snapshots the PE accumulator array on `done` and
// streams the captured values out in row-major order over valid/ready.
module result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 2,
  parameter int ROWS       = 4,
  parameter int COLS       = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              done,
  input  logic [ROWS*COLS*ACC_WIDTH-1:0]    acc_flat,
  input  logic                              out_ready,
  output logic                              out_valid,
  output logic [ACC_WIDTH-1:0]              out_data,
  output logic [$clog2(ROWS*COLS)-1:0]      out_index,
  output logic                              out_last,
  output logic                              busy,
  output logic                              overrun,
  input  logic                              clear_err
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = $clog2(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     index;
  logic [ACC_WIDTH-1:0] bank [N];

  logic handshake;
  logic final_handshake;
  logic load;
  logic done_ignored;

  assign handshake       = (state == DRAIN) && out_ready;
  assign final_handshake = handshake && (index == LAST_IDX);

  // A done on the final handshake is a back-to-back capture, not an overrun.
  assign load         = done && ((state == IDLE) || final_handshake);
  assign done_ignored = done && (state == DRAIN) && !final_handshake;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      index   <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            index <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (handshake) begin
            if (index == LAST_IDX) begin
              index <= '0;
              if (!done) begin
                state <= IDLE;
              end
            end else begin
              index <= index + IDX_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase

      if (done_ignored) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        bank[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < N; i++) begin
        bank[i] <= acc_flat[i*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  assign out_valid = (state == DRAIN);
  assign busy      = (state == DRAIN);
  assign out_data  = bank[index];
  assign out_index = index;
  assign out_last  = (state == DRAIN) && (index == LAST_IDX);

endmodule

// File: doc/result_drain.md
# result_drain

Result readout stage that sits directly downstream of the 4x4 systolic PE array and its controller. When the controller pulses `done`, the block snapshots all PE accumulators in one cycle. It then streams the results out one element per handshake, in row-major order, over a valid/ready interface. This frees the array to start the next computation while the previous results are still draining.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: operand width of matrices A/B.
- `ACC_WIDTH`, default 18: accumulator width per PE, equal to 2*DATA_WIDTH+2.
- `ROWS`, default 4: PE rows.
- `COLS`, default 4: PE columns.
- `N` (localparam): ROWS*COLS = 16.
- `IDX_W` (localparam): $clog2(N) = 4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `done` in 1: one-cycle pulse from the controller; accumulators are final in this cycle.
- `acc_flat` in N*ACC_WIDTH: all PE accumulators. Element (r,c) is at bits [(r*COLS+c)*ACC_WIDTH +: ACC_WIDTH].
- `out_ready` in 1: downstream consumer ready.
- `out_valid` out 1: `out_data` holds a valid element.
- `out_data` out ACC_WIDTH: current element.
- `out_index` out IDX_W: linear index r*COLS+c of the current element.
- `out_last` out 1: high when out_valid is high and out_index == N-1.
- `busy` out 1: high while in DRAIN.
- `overrun` out 1: sticky error flag; a `done` arrived while results were still pending.
- `clear_err` in 1: synchronous clear of `overrun`.

## Operation

- Storage: snapshot bank of N x ACC_WIDTH registers, plus an index counter (IDX_W bits) and a 1-bit state register.
- States: IDLE and DRAIN.

IDLE:
- out_valid=0 and busy=0.
- On `done`: load all N bank entries from `acc_flat`, set index=0, go to DRAIN.

DRAIN:
- out_valid=1 and busy=1.
- out_data=bank[index] and out_index=index.
- A handshake is out_valid && out_ready.
- Handshake with index<N-1: index increments by 1.
- Handshake with index==N-1: go to IDLE and index returns to 0.
- No handshake: index, out_data and out_index hold.

Simultaneous events:
- `done` in the same cycle as the final handshake (index==N-1): this is a back-to-back capture. Reload the bank, set index=0, stay in DRAIN. `overrun` is not set.
- `done` in DRAIN at any other time: ignored. The bank is not modified and `overrun` is set to 1.
- `overrun` set and `clear_err` in the same cycle: set wins.

Arithmetic and data rules:
- Accumulator values pass through unmodified; no truncation or sign change.
- The index does not wrap past N-1 within a drain.

Reset:
- Reset (asynchronous, including mid-drain) forces IDLE, index=0, the whole bank to 0 and overrun=0.
- All outputs are 0 during and after reset: out_valid, out_data, out_index, out_last, busy, overrun.
- A partially drained result set is discarded.

## Timing

- `done` sampled high at edge T: out_valid=1 with element 0 from edge T (visible in cycle T+1).
- Capture is a single-cycle latency.
- With out_ready held high: elements 0..15 appear on 16 consecutive cycles, out_last is high on the 16th, and out_valid falls after that edge.
- Drain-to-idle total: 17 cycles after `done`.
- out_data, out_index and out_last are register-driven (bank mux over registered state) and glitch-free relative to clk.
- They stay stable while out_valid=1 and out_ready=0.
- `out_ready` may toggle on any cycle. The block never deasserts out_valid before a handshake.
- `acc_flat` only needs to be valid in the cycle where `done`=1. The PE array may be reset or reloaded from the next cycle on.

## Test plan

- Basic drain: acc_flat element k = 100+k, pulse done, hold out_ready=1.
  - Values 100..115 appear with out_index 0..15 on 16 consecutive cycles.
  - out_last only with 115.
  - busy drops on the next cycle.
- Backpressure: same load, out_ready pattern 1,0,0,1 repeating.
  - Each value is held stable through the stalls.
  - No value is skipped or duplicated.
  - Exactly 16 handshakes total.
- Snapshot isolation: after done, change acc_flat to all 0x3FFFF mid-drain.
  - The output still shows the captured values 100..115.
- Overrun: pulse done at index 5.
  - The output stream is unchanged (105..115).
  - overrun=1 and stays high.
  - clear_err in IDLE returns it to 0.
- Back-to-back: second done (values 200+k) on the cycle of the index-15 handshake.
  - The next cycle shows 200 at index 0 with busy held high.
  - overrun stays 0.
- Reset mid-drain: assert rst_n=0 at index 7.
  - All outputs are 0 immediately.
  - After release, the block is in IDLE.
  - A new done starts again from index 0.
